// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory access unit
package dmem_pkg;

  localparam int XLEN       = 64;
  localparam int ALIGN_BITS = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Misaligned doubleword, or any address bit above the array index is set (no aliasing).
  function automatic logic addr_fault(input logic [XLEN-1:0] addr, input int idx_w);
    return (addr[ALIGN_BITS-1:0] != '0) || ((addr >> (ALIGN_BITS + idx_w)) != '0);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - doubleword storage, synchronous write, combinational read, no reset
module dmem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [63:0]      wdata_i,
  output logic [63:0]      rdata_o
);

  logic [63:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/dmem_access_unit.sv
// rtl/dmem_access_unit.sv - ld/sd stage: one request at a time, fixed latency, fault on bad address
module dmem_access_unit
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_fault
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  // Counter counts down to zero; the edge leaving BUSY at zero lands resp_valid LATENCY edges after accept.
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                wr_q, wr_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [XLEN-1:0]     wdata_q, wdata_d;
  logic                fault_q, fault_d;
  logic [XLEN-1:0]     rdata_q, rdata_d;
  logic                rfault_q, rfault_d;
  logic                mem_we;
  logic [XLEN-1:0]     mem_rdata;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk_i  (clk),
    .we_i   (mem_we),
    .idx_i  (idx_q),
    .wdata_i(wdata_q),
    .rdata_o(mem_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      wr_q     <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= '0;
      fault_q  <= 1'b0;
      rdata_q  <= '0;
      rfault_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      idx_q    <= idx_d;
      wdata_q  <= wdata_d;
      fault_q  <= fault_d;
      rdata_q  <= rdata_d;
      rfault_q <= rfault_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    fault_d  = fault_q;
    rdata_d  = rdata_q;
    rfault_d = rfault_q;
    mem_we   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          wr_d    = req_write;
          idx_d   = req_addr[ALIGN_BITS +: IDX_W];
          wdata_d = req_wdata;
          fault_d = addr_fault(req_addr, IDX_W);
          cnt_d   = CNT_INIT;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) begin
          mem_we   = wr_q && !fault_q;
          rdata_d  = (wr_q || fault_q) ? '0 : mem_rdata;
          rfault_d = fault_q;
          state_d  = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          rdata_d  = '0;
          rfault_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = rdata_q;
  assign resp_fault = rfault_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// tb/tb_dmem_access_unit.sv - randomized and directed checks against a word-map reference model
module tb_dmem_access_unit;

  localparam int D0 = 1024;
  localparam int L0 = 2;
  localparam int D1 = 16;
  localparam int L1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic req_valid0, req_ready0, req_write0, resp_valid0, resp_ready0, resp_fault0;
  logic [63:0] req_addr0, req_wdata0, resp_rdata0;
  logic req_valid1, req_ready1, req_write1, resp_valid1, resp_ready1, resp_fault1;
  logic [63:0] req_addr1, req_wdata1, resp_rdata1;

  dmem_access_unit #(.DEPTH_WORDS(D0), .LATENCY(L0)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_write(req_write0),
    .req_addr(req_addr0), .req_wdata(req_wdata0),
    .resp_valid(resp_valid0), .resp_ready(resp_ready0),
    .resp_rdata(resp_rdata0), .resp_fault(resp_fault0)
  );

  dmem_access_unit #(.DEPTH_WORDS(D1), .LATENCY(L1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_write(req_write1),
    .req_addr(req_addr1), .req_wdata(req_wdata1),
    .resp_valid(resp_valid1), .resp_ready(resp_ready1),
    .resp_rdata(resp_rdata1), .resp_fault(resp_fault1)
  );

  int errors = 0;
  int checks = 0;
  bit sel = 1'b0;
  logic [63:0] mem0 [longint];
  logic [63:0] mem1 [longint];

  logic        cur_rr, cur_rv, cur_f;
  logic [63:0] cur_rd;
  assign cur_rr = sel ? req_ready1  : req_ready0;
  assign cur_rv = sel ? resp_valid1 : resp_valid0;
  assign cur_f  = sel ? resp_fault1 : resp_fault0;
  assign cur_rd = sel ? resp_rdata1 : resp_rdata0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic w, input logic [63:0] a, input logic [63:0] d);
    if (sel) begin
      req_valid1 = v; req_write1 = w; req_addr1 = a; req_wdata1 = d;
    end else begin
      req_valid0 = v; req_write0 = w; req_addr0 = a; req_wdata0 = d;
    end
  endtask

  task automatic set_rr(input logic r);
    if (sel) resp_ready1 = r;
    else     resp_ready0 = r;
  endtask

  task automatic op(input bit w, input logic [63:0] a, input logic [63:0] d, input int hold);
    int          depth, latency, lat;
    longint      idx;
    bit          known;
    logic        ef, f_s;
    logic [63:0] erd, rd_s;
    depth   = sel ? D1 : D0;
    latency = sel ? L1 : L0;
    idx     = longint'(a >> 3);
    ef      = (a[2:0] != 3'd0) || ((a >> 3) >= 64'(depth));
    known   = 1'b1;
    erd     = '0;
    if (!ef && !w) begin
      if (sel) begin
        if (mem1.exists(idx)) erd = mem1[idx]; else known = 1'b0;
      end else begin
        if (mem0.exists(idx)) erd = mem0[idx]; else known = 1'b0;
      end
    end

    @(negedge clk);
    chk("req_ready_idle", 64'(cur_rr), 64'(1));
    drive(1'b1, w, a, d);
    @(posedge clk); #1;
    drive(1'b0, 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
    lat = 0;
    while (!cur_rv && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'(latency));
    chk("req_ready_resp", 64'(cur_rr), 64'(0));
    rd_s = cur_rd;
    f_s  = cur_f;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 64'(cur_rv), 64'(1));
      chk("hold_rdata", cur_rd, rd_s);
      chk("hold_fault", 64'(cur_f), 64'(f_s));
      chk("hold_ready", 64'(cur_rr), 64'(0));
    end
    if (known) chk("rdata", cur_rd, erd);
    chk("fault", 64'(cur_f), 64'(ef));
    set_rr(1'b1);
    @(posedge clk); #1;
    set_rr(1'b0);
    chk("post_valid", 64'(cur_rv), 64'(0));
    chk("post_rdata", cur_rd, 64'(0));
    chk("post_fault", 64'(cur_f), 64'(0));
    chk("post_ready", 64'(cur_rr), 64'(1));
    if (w && !ef) begin
      if (sel) mem1[idx] = d; else mem0[idx] = d;
    end
  endtask

  task automatic reset_in_busy(input logic [63:0] a, input logic [63:0] d);
    @(negedge clk);
    drive(1'b1, 1'b1, a, d);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, '0, '0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", 64'(cur_rv), 64'(0));
    chk("rst_ready", 64'(cur_rr), 64'(1));
    chk("rst_rdata", cur_rd, 64'(0));
    chk("rst_fault", 64'(cur_f), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [63:0] a;
    int          kind;
    rst_n = 1'b0;
    req_valid0 = 0; req_write0 = 0; req_addr0 = '0; req_wdata0 = '0; resp_ready0 = 0;
    req_valid1 = 0; req_write1 = 0; req_addr1 = '0; req_wdata1 = '0; resp_ready1 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", 64'(req_ready0), 64'(1));
    chk("reset_valid", 64'(resp_valid0), 64'(0));
    chk("reset_rdata", resp_rdata0, 64'(0));
    chk("reset_fault", 64'(resp_fault0), 64'(0));
    chk("reset_ready1", 64'(req_ready1), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;

    sel = 1'b0;
    op(1'b1, 64'h10, 64'hDEADBEEF_CAFEF00D, 0);
    op(1'b0, 64'h10, 64'h0, 0);
    op(1'b1, 64'h13, 64'h1, 0);
    op(1'b0, 64'h10, 64'h0, 0);
    op(1'b0, 64'h2000, 64'h0, 0);
    op(1'b1, 64'h8000_0000_0000_0010, 64'h1234, 0);
    op(1'b0, 64'h10, 64'h0, 0);
    op(1'b1, 64'h1FF8, 64'h5A5A, 0);
    op(1'b0, 64'h1FF8, 64'h0, 0);
    op(1'b0, 64'h10, 64'h0, 5);
    op(1'b1, 64'h13, 64'h1, 5);

    reset_in_busy(64'h20, 64'h77);
    op(1'b1, 64'h20, 64'h11, 0);
    reset_in_busy(64'h20, 64'h99);
    op(1'b0, 64'h20, 64'h0, 0);
    chk("raw_after_reset", mem0[4], 64'h11);

    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 9));
      if (kind <= 5)      a = 64'($urandom_range(0, 15)) * 8;
      else if (kind == 6) a = 64'h1FF8;
      else if (kind == 7) a = 64'($urandom_range(0, 15)) * 8 + 64'($urandom_range(1, 7));
      else if (kind == 8) begin
        a = {$urandom, $urandom};
        if ((a >> 3) < 64'(D0)) a = a | 64'h4000;
      end
      else                a = 64'($urandom_range(0, D0 - 1)) * 8;
      op(1'($urandom_range(0, 1)), a, {$urandom, $urandom}, int'($urandom_range(0, 2)));
    end

    sel = 1'b1;
    op(1'b1, 64'h8, 64'hABC, 0);
    op(1'b0, 64'h8, 64'h0, 0);
    op(1'b0, 64'h80, 64'h0, 2);
    op(1'b1, 64'h78, 64'hFEED, 1);
    op(1'b0, 64'h78, 64'h0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
